// File: rtl/snake_turn_queue_if.sv
// Button/step/clear inputs and per-player direction outputs of the snake turn queue.
// The game side drives through master; the queue block attaches as slave.
interface snake_turn_queue_if #(
   parameter int NUM_PLAYERS = 2
);
   logic [NUM_PLAYERS-1:0]   i_Up;
   logic [NUM_PLAYERS-1:0]   i_Down;
   logic [NUM_PLAYERS-1:0]   i_Left;
   logic [NUM_PLAYERS-1:0]   i_Right;
   logic                     i_Step;
   logic                     i_Clear;
   logic [2*NUM_PLAYERS-1:0] o_Dir;
   logic [NUM_PLAYERS-1:0]   o_Turned;
   logic [NUM_PLAYERS-1:0]   o_Overflow;

   modport master (
      output i_Up, i_Down, i_Left, i_Right, i_Step, i_Clear,
      input  o_Dir, o_Turned, o_Overflow
   );

   modport slave (
      input  i_Up, i_Down, i_Left, i_Right, i_Step, i_Clear,
      output o_Dir, o_Turned, o_Overflow
   );
endinterface

// File: rtl/snake_turn_queue.sv
// Per-player buffered steering: button presses are validated against the newest
// pending turn and queued in a small circular FIFO, then committed one per game tick.
module snake_turn_queue #(
   parameter int         NUM_PLAYERS = 2,
   parameter int         QUEUE_DEPTH = 2,
   parameter int         REL_MODE    = 0,
   parameter logic [1:0] INIT_DIR    = 2'b11
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   snake_turn_queue_if.slave  bus
);

   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   function automatic logic [PTR_W-1:0] f_Next_Ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] f_Prev_Ptr(input logic [PTR_W-1:0] p);
      return (p == '0) ? LAST_PTR : p - PTR_W'(1);
   endfunction

   // Clockwise: UP -> RIGHT -> DOWN -> LEFT -> UP
   function automatic logic [1:0] f_Rot_Cw(input logic [1:0] d);
      case (d)
         DIR_UP:    return DIR_RIGHT;
         DIR_RIGHT: return DIR_DOWN;
         DIR_DOWN:  return DIR_LEFT;
         default:   return DIR_UP;
      endcase
   endfunction

   function automatic logic [1:0] f_Rot_Ccw(input logic [1:0] d);
      case (d)
         DIR_UP:    return DIR_LEFT;
         DIR_LEFT:  return DIR_DOWN;
         DIR_DOWN:  return DIR_RIGHT;
         default:   return DIR_UP;
      endcase
   endfunction

   // Previous button levels reset high so a button held through reset is not a press.
   logic [NUM_PLAYERS-1:0] r_Prev_Up;
   logic [NUM_PLAYERS-1:0] r_Prev_Down;
   logic [NUM_PLAYERS-1:0] r_Prev_Left;
   logic [NUM_PLAYERS-1:0] r_Prev_Right;

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_Prev_Up    <= '1;
         r_Prev_Down  <= '1;
         r_Prev_Left  <= '1;
         r_Prev_Right <= '1;
      end else begin
         r_Prev_Up    <= bus.i_Up;
         r_Prev_Down  <= bus.i_Down;
         r_Prev_Left  <= bus.i_Left;
         r_Prev_Right <= bus.i_Right;
      end
   end

   logic [2*NUM_PLAYERS-1:0] w_Dir_All;
   logic [NUM_PLAYERS-1:0]   w_Turned_All;
   logic [NUM_PLAYERS-1:0]   w_Ovf_All;

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
      logic [1:0]       r_Q [QUEUE_DEPTH];
      logic [PTR_W-1:0] r_Rptr;
      logic [PTR_W-1:0] r_Wptr;
      logic [CNT_W-1:0] r_Cnt;
      logic [1:0]       r_Dir;
      logic             r_Turned;
      logic             r_Ovf;

      logic             w_Press_Up;
      logic             w_Press_Down;
      logic             w_Press_Left;
      logic             w_Press_Right;
      logic [1:0]       w_Tail;
      logic [1:0]       w_Req;
      logic             w_Valid;
      logic             w_Pop;
      logic             w_Push;

      always_comb begin
         w_Press_Up    = bus.i_Up[p]    & ~r_Prev_Up[p];
         w_Press_Down  = bus.i_Down[p]  & ~r_Prev_Down[p];
         w_Press_Left  = bus.i_Left[p]  & ~r_Prev_Left[p];
         w_Press_Right = bus.i_Right[p] & ~r_Prev_Right[p];
      end

      // Requests are judged against the newest pending turn, not the committed one.
      always_comb begin
         w_Tail  = (r_Cnt != '0) ? r_Q[f_Prev_Ptr(r_Wptr)] : r_Dir;
         w_Req   = w_Tail;
         w_Valid = 1'b0;
         if (REL_MODE != 0) begin
            if (w_Press_Left ^ w_Press_Right) begin
               w_Valid = 1'b1;
               w_Req   = w_Press_Right ? f_Rot_Cw(w_Tail) : f_Rot_Ccw(w_Tail);
            end
         end else begin
            if (w_Press_Up)
               w_Req = DIR_UP;
            else if (w_Press_Down)
               w_Req = DIR_DOWN;
            else if (w_Press_Left)
               w_Req = DIR_LEFT;
            else
               w_Req = DIR_RIGHT;
            w_Valid = (w_Press_Up | w_Press_Down | w_Press_Left | w_Press_Right) &&
                      (w_Req != w_Tail) && (w_Req != (w_Tail ^ 2'b01));
         end
         w_Pop  = bus.i_Step && (r_Cnt != '0);
         w_Push = w_Valid && ((r_Cnt != FULL_CNT) || w_Pop);
      end

      always_ff @(posedge i_Clk or posedge i_Rst) begin
         if (i_Rst) begin
            r_Rptr   <= '0;
            r_Wptr   <= '0;
            r_Cnt    <= '0;
            r_Dir    <= INIT_DIR;
            r_Turned <= 1'b0;
            r_Ovf    <= 1'b0;
         end else if (bus.i_Clear) begin
            r_Rptr   <= '0;
            r_Wptr   <= '0;
            r_Cnt    <= '0;
            r_Dir    <= INIT_DIR;
            r_Turned <= 1'b0;
            r_Ovf    <= 1'b0;
         end else begin
            r_Turned <= w_Pop;
            if (w_Pop) begin
               r_Dir  <= r_Q[r_Rptr];
               r_Rptr <= f_Next_Ptr(r_Rptr);
            end
            if (w_Push)
               r_Wptr <= f_Next_Ptr(r_Wptr);
            if (w_Push && !w_Pop)
               r_Cnt <= r_Cnt + CNT_W'(1);
            else if (!w_Push && w_Pop)
               r_Cnt <= r_Cnt - CNT_W'(1);
            if (w_Valid && !w_Push)
               r_Ovf <= 1'b1;
         end
      end

      // Entry storage needs no reset: occupancy is tracked by r_Cnt alone.
      always_ff @(posedge i_Clk) begin
         if (w_Push)
            r_Q[r_Wptr] <= w_Req;
      end

      assign w_Dir_All[2*p +: 2] = r_Dir;
      assign w_Turned_All[p]     = r_Turned;
      assign w_Ovf_All[p]        = r_Ovf;
   end

   assign bus.o_Dir      = w_Dir_All;
   assign bus.o_Turned   = w_Turned_All;
   assign bus.o_Overflow = w_Ovf_All;

endmodule

// File: tb/tb_snake_turn_queue.sv
// Bench for snake_turn_queue: an absolute-mode and a relative-mode instance share
// the same button stimulus and are compared every cycle against a queue-based model.
module tb_snake_turn_queue;

   localparam int NP = 2;
   localparam logic [7:0] CW_SEQ = 8'b00_11_01_10;

   logic i_Clk = 1'b0;
   logic i_Rst = 1'b1;
   always #5 i_Clk = ~i_Clk;

   logic [NP-1:0] r_Up = '0, r_Down = '0, r_Left = '0, r_Right = '0;
   logic          r_Step = 1'b0, r_Clear = 1'b0;

   snake_turn_queue_if #(.NUM_PLAYERS(NP)) abs_if ();
   snake_turn_queue_if #(.NUM_PLAYERS(NP)) rel_if ();

   assign abs_if.i_Up = r_Up;       assign rel_if.i_Up = r_Up;
   assign abs_if.i_Down = r_Down;   assign rel_if.i_Down = r_Down;
   assign abs_if.i_Left = r_Left;   assign rel_if.i_Left = r_Left;
   assign abs_if.i_Right = r_Right; assign rel_if.i_Right = r_Right;
   assign abs_if.i_Step = r_Step;   assign rel_if.i_Step = r_Step;
   assign abs_if.i_Clear = r_Clear; assign rel_if.i_Clear = r_Clear;

   snake_turn_queue #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(2), .REL_MODE(0), .INIT_DIR(2'b11)) u_abs (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .bus(abs_if.slave));

   snake_turn_queue #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(3), .REL_MODE(1), .INIT_DIR(2'b11)) u_rel (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .bus(rel_if.slave));

   // Model: index 0 = absolute instance (depth 2), index 1 = relative instance (depth 3)
   logic [1:0]    m_q    [2][NP][$];
   logic [1:0]    m_dir  [2][NP];
   logic          m_turn [2][NP];
   logic          m_ovf  [2][NP];
   logic [NP-1:0] m_pu, m_pd, m_pl, m_pr;
   logic [1:0]    exp32 [4];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] rot(input logic [1:0] d, input logic cw);
      logic [7:0] seq;
      int idx;
      seq = CW_SEQ;
      idx = 0;
      for (int i = 0; i < 4; i++)
         if (seq[7-2*i -: 2] == d) idx = i;
      idx = cw ? (idx + 1) % 4 : (idx + 3) % 4;
      return seq[7-2*idx -: 2];
   endfunction

   function automatic logic [1:0] opposite(input logic [1:0] d);
      case (d)
         2'b00:   return 2'b01;
         2'b01:   return 2'b00;
         2'b10:   return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < NP; p++) begin
            m_q[d][p].delete();
            m_dir[d][p]  = 2'b11;
            m_turn[d][p] = 1'b0;
            m_ovf[d][p]  = 1'b0;
         end
      m_pu = '1; m_pd = '1; m_pl = '1; m_pr = '1;
   endtask

   task automatic model_edge();
      logic pu, pd, pl, pr, valid, popping;
      logic [1:0] tail, nd;
      int sz, depth;
      for (int p = 0; p < NP; p++) begin
         pu = r_Up[p] & ~m_pu[p];
         pd = r_Down[p] & ~m_pd[p];
         pl = r_Left[p] & ~m_pl[p];
         pr = r_Right[p] & ~m_pr[p];
         for (int d = 0; d < 2; d++) begin
            depth = (d == 0) ? 2 : 3;
            if (r_Clear) begin
               m_q[d][p].delete();
               m_dir[d][p]  = 2'b11;
               m_turn[d][p] = 1'b0;
               m_ovf[d][p]  = 1'b0;
               continue;
            end
            sz   = m_q[d][p].size();
            tail = (sz > 0) ? m_q[d][p][$] : m_dir[d][p];
            valid = 1'b0;
            nd    = tail;
            if (d == 1) begin
               if (pl != pr) begin
                  valid = 1'b1;
                  nd    = rot(tail, pr);
               end
            end else if (pu | pd | pl | pr) begin
               nd    = pu ? 2'b00 : pd ? 2'b01 : pl ? 2'b10 : 2'b11;
               valid = (nd != tail) && (nd != opposite(tail));
            end
            popping = r_Step && (sz > 0);
            if (popping) begin
               m_dir[d][p]  = m_q[d][p].pop_front();
               m_turn[d][p] = 1'b1;
            end else begin
               m_turn[d][p] = 1'b0;
            end
            if (valid) begin
               if (sz < depth || popping) m_q[d][p].push_back(nd);
               else                       m_ovf[d][p] = 1'b1;
            end
         end
      end
      m_pu = r_Up; m_pd = r_Down; m_pl = r_Left; m_pr = r_Right;
   endtask

   task automatic compare_all(input string tag);
      logic [2*NP-1:0] e_dir [2];
      logic [NP-1:0]   e_turn [2];
      logic [NP-1:0]   e_ovf [2];
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < NP; p++) begin
            e_dir[d][2*p +: 2] = m_dir[d][p];
            e_turn[d][p]       = m_turn[d][p];
            e_ovf[d][p]        = m_ovf[d][p];
         end
      chk_eq({tag, "_abs_dir"},  32'(abs_if.o_Dir),      32'(e_dir[0]));
      chk_eq({tag, "_abs_turn"}, 32'(abs_if.o_Turned),   32'(e_turn[0]));
      chk_eq({tag, "_abs_ovf"},  32'(abs_if.o_Overflow), 32'(e_ovf[0]));
      chk_eq({tag, "_rel_dir"},  32'(rel_if.o_Dir),      32'(e_dir[1]));
      chk_eq({tag, "_rel_turn"}, 32'(rel_if.o_Turned),   32'(e_turn[1]));
      chk_eq({tag, "_rel_ovf"},  32'(rel_if.o_Overflow), 32'(e_ovf[1]));
   endtask

   task automatic cyc();
      @(posedge i_Clk);
      if (!i_Rst) model_edge();
      #1;
      compare_all("cyc");
   endtask

   task automatic press(input logic [NP-1:0] u, input logic [NP-1:0] dn,
                        input logic [NP-1:0] l, input logic [NP-1:0] r);
      r_Up = u; r_Down = dn; r_Left = l; r_Right = r;
      cyc();
      r_Up = '0; r_Down = '0; r_Left = '0; r_Right = '0;
      cyc();
   endtask

   task automatic step_once();
      r_Step = 1'b1;
      cyc();
      r_Step = 1'b0;
   endtask

   task automatic clear_all();
      r_Clear = 1'b1;
      cyc();
      r_Clear = 1'b0;
   endtask

   initial begin
      exp32 = '{2'b11, 2'b01, 2'b10, 2'b00};
      model_reset();
      repeat (2) @(posedge i_Clk);
      #1;
      chk_eq("rst_abs_dir", 32'(abs_if.o_Dir), 32'hF);
      chk_eq("rst_abs_turn", 32'(abs_if.o_Turned), 32'h0);
      chk_eq("rst_rel_ovf", 32'(rel_if.o_Overflow), 32'h0);
      compare_all("rst");
      i_Rst = 1'b0;
      cyc(); cyc();

      // Press and step on the same edge: no bypass, turn lands at the next step
      r_Up = 2'b01; r_Step = 1'b1;
      cyc();
      chk_eq("lat_hold", 32'(abs_if.o_Dir[1:0]), 32'(2'b11));
      r_Step = 1'b0;
      cyc(); cyc();
      r_Step = 1'b1;
      cyc();
      chk_eq("lat_dir", 32'(abs_if.o_Dir[1:0]), 32'(2'b00));
      chk_eq("lat_turn", 32'(abs_if.o_Turned[0]), 32'(1'b1));
      r_Step = 1'b0;
      cyc();
      chk_eq("lat_turn_end", 32'(abs_if.o_Turned[0]), 32'(1'b0));
      r_Up = '0;
      cyc();

      // Reversal discarded; two queued turns committed in order
      clear_all();
      press('0, '0, 2'b01, '0);
      step_once();
      chk_eq("rev_dir", 32'(abs_if.o_Dir[1:0]), 32'(2'b11));
      chk_eq("rev_turn", 32'(abs_if.o_Turned[0]), 32'(1'b0));
      press(2'b01, '0, '0, '0);
      press('0, '0, 2'b01, '0);
      step_once();
      chk_eq("two_first", 32'(abs_if.o_Dir[1:0]), 32'(2'b00));
      step_once();
      chk_eq("two_second", 32'(abs_if.o_Dir[1:0]), 32'(2'b10));

      // Overflow is sticky until clear
      clear_all();
      press(2'b01, '0, '0, '0);
      press('0, '0, 2'b01, '0);
      press('0, 2'b01, '0, '0);
      chk_eq("ovf_set", 32'(abs_if.o_Overflow[0]), 32'(1'b1));
      step_once(); step_once();
      chk_eq("ovf_sticky", 32'(abs_if.o_Overflow[0]), 32'(1'b1));
      chk_eq("ovf_dir", 32'(abs_if.o_Dir[1:0]), 32'(2'b10));
      clear_all();
      chk_eq("ovf_clr", 32'(abs_if.o_Overflow[0]), 32'(1'b0));

      // Relative steering on player 1
      press('0, '0, 2'b10, '0);
      step_once();
      chk_eq("rel_up", 32'(rel_if.o_Dir[3:2]), 32'(2'b00));
      for (int i = 0; i < 4; i++) begin
         press('0, '0, '0, 2'b10);
         step_once();
         chk_eq($sformatf("rel_cw%0d", i), 32'(rel_if.o_Dir[3:2]), 32'(exp32[i]));
      end

      // Full queue + push + step on one edge; then clear beats step
      clear_all();
      press(2'b01, '0, '0, '0);
      press('0, '0, 2'b01, '0);
      r_Down = 2'b01; r_Step = 1'b1;
      cyc();
      chk_eq("fullpush_dir", 32'(abs_if.o_Dir[1:0]), 32'(2'b00));
      chk_eq("fullpush_ovf", 32'(abs_if.o_Overflow[0]), 32'(1'b0));
      r_Down = '0; r_Step = 1'b0;
      cyc();
      r_Clear = 1'b1; r_Step = 1'b1;
      cyc();
      chk_eq("clrstep_dir", 32'(abs_if.o_Dir[1:0]), 32'(2'b11));
      chk_eq("clrstep_turn", 32'(abs_if.o_Turned), 32'h0);
      r_Clear = 1'b0; r_Step = 1'b0;
      cyc();
      chk_eq("clrstep_turn2", 32'(abs_if.o_Turned), 32'h0);

      // Asynchronous reset mid-operation, then a button held through release
      press(2'b01, '0, '0, '0);
      press('0, '0, 2'b01, '0);
      step_once();
      #2 i_Rst = 1'b1;
      #1 model_reset();
      compare_all("arst");
      chk_eq("arst_turn", 32'(abs_if.o_Turned), 32'h0);
      chk_eq("arst_dir", 32'(abs_if.o_Dir), 32'hF);
      r_Up = 2'b01;
      repeat (2) @(posedge i_Clk);
      #1 i_Rst = 1'b0;
      cyc(); cyc();
      step_once();
      chk_eq("held_noenq", 32'(abs_if.o_Dir[1:0]), 32'(2'b11));
      r_Up = '0;
      cyc();
      press(2'b01, '0, '0, '0);
      step_once();
      chk_eq("held_reenq", 32'(abs_if.o_Dir[1:0]), 32'(2'b00));

      // Randomized phase
      clear_all();
      repeat (600) begin
         if ($urandom_range(0, 3) == 0) r_Up    = NP'($urandom);
         if ($urandom_range(0, 3) == 0) r_Down  = NP'($urandom);
         if ($urandom_range(0, 3) == 0) r_Left  = NP'($urandom);
         if ($urandom_range(0, 3) == 0) r_Right = NP'($urandom);
         r_Step  = ($urandom_range(0, 3) == 0);
         r_Clear = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 150) == 0) begin
            #2 i_Rst = 1'b1;
            #1 model_reset();
            compare_all("rnd_arst");
            @(posedge i_Clk);
            #1 i_Rst = 1'b0;
         end
         cyc();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/snake_turn_queue.md
SNAKE_TURN_QUEUE -- requirements
Module: snake_turn_queue

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, meaning the number of independent snake channels (1..4).
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2, meaning the pending-turn entries per channel (1..8).
REQ-003 SHALL have parameter REL_MODE, default 0, selecting absolute steering (0) or relative steering (1).
REQ-004 SHALL have parameter INIT_DIR, default 2'b11 (RIGHT), meaning the direction loaded at reset and clear.
REQ-005 SHALL have port i_Clk, input, 1, the single clock; all flops are on the rising edge.
REQ-006 SHALL have port i_Rst, input, 1, the reset: asynchronous and active-high.
REQ-007 SHALL have ports i_Up, i_Down, i_Left, i_Right, input, NUM_PLAYERS each, carrying debounced, synchronised button levels (bit p = player p).
REQ-008 SHALL have port i_Step, input, 1, a one-cycle game-tick pulse.
REQ-009 SHALL have port i_Clear, input, 1, a synchronous flush of all channels.
REQ-010 SHALL have port o_Dir, output, 2*NUM_PLAYERS, carrying each player's committed direction in bits [2p+1:2p]; UP=00, DOWN=01, LEFT=10, RIGHT=11.
REQ-011 SHALL have port o_Turned, output, NUM_PLAYERS, a one-cycle pulse when that player's o_Dir changed.
REQ-012 SHALL have port o_Overflow, output, NUM_PLAYERS, a sticky flag set when a valid turn was dropped because the queue was full.

Function
REQ-013 Press detection SHALL be a rising edge per button: current level 1 and registered previous level 0; presses SHALL be evaluated at the same clock edge.
REQ-014 When an absolute-mode channel sees multiple presses in one cycle, it SHALL take only one, with priority Up > Down > Left > Right.
REQ-015 In relative mode, Up/Down SHALL be ignored; Left SHALL rotate CCW and Right SHALL rotate CW; Left and Right together SHALL be ignored. CW order is UP->RIGHT->DOWN->LEFT->UP.
REQ-016 The tail direction SHALL be the newest queued entry if count>0, else o_Dir; each request SHALL be evaluated against the tail.
REQ-017 In absolute mode, a request equal to the tail or opposite to it (UP/DOWN, LEFT/RIGHT) SHALL be discarded silently.
REQ-018 In relative mode, the new direction SHALL be the rotation of the tail; it is always valid.
REQ-019 A valid request SHALL be pushed at that edge if count<QUEUE_DEPTH, or if count==QUEUE_DEPTH and the same edge pops; otherwise it SHALL be dropped and o_Overflow[p] SHALL be set.
REQ-020 On i_Step with count>0, the head SHALL be popped into o_Dir and o_Turned[p] SHALL be 1 for exactly the following cycle; with count==0, o_Dir SHALL hold and o_Turned[p]=0.
REQ-021 A push and a pop at the same edge SHALL both occur; the pushed entry SHALL never bypass to o_Dir, so the minimum latency is press edge k -> o_Dir update at the first i_Step edge > k.
REQ-022 At most one entry per channel per i_Step SHALL be popped.
REQ-023 The queue SHALL be circular (read/write pointers wrap modulo QUEUE_DEPTH), and count SHALL stay in 0..QUEUE_DEPTH.
REQ-024 i_Clear SHALL empty all queues, load o_Dir=INIT_DIR, and clear o_Turned and o_Overflow; it SHALL take priority over push and step in the same cycle.
REQ-025 Channels SHALL be fully independent; no channel's state SHALL affect another.

Reset
REQ-026 While i_Rst=1, the block SHALL force: o_Dir=INIT_DIR for every player, queues empty, o_Turned=0, o_Overflow=0.
REQ-027 Previous-level button registers SHALL reset to 1, so a button held through reset release produces no press until released and re-pressed.
REQ-028 Assertion of i_Rst mid-operation SHALL discard queued turns immediately (asynchronously), with no o_Turned pulse.

Verification
REQ-029 Absolute mode, P0 at RIGHT: press Up at edge 5, i_Step at edge 5 -> o_Dir[1:0] stays 11; i_Step at edge 8 -> o_Dir[1:0]=00, o_Turned[0]=1 for one cycle.
REQ-030 Absolute mode, P0 at RIGHT: press Left -> discarded (reversal); press Up then Left before a step -> two entries; two steps -> UP then LEFT.
REQ-031 QUEUE_DEPTH=2, P0 at RIGHT: press Up, Left, Down with no step -> third press dropped, o_Overflow[0]=1, stays 1 across subsequent steps until i_Clear.
REQ-032 REL_MODE=1, P1 at UP: press Right four times with a step between each -> o_Dir[3:2] = 11, 01, 10, 00.
REQ-033 Queue full plus push plus i_Step at the same edge -> head popped, new entry accepted, o_Overflow stays 0; i_Clear with the same i_Step -> o_Dir=INIT_DIR, no o_Turned pulse.
REQ-034 Hold Up through i_Rst release -> no enqueue; release then press Up -> enqueued normally.
